mem_port_arbiter: RTL and testbench

- Shares the single-ported data RAM between two requesters: the memory-access stage (data port, D) and the instruction-fetch stage (fetch port, I).
- Sits between those stages and the RAM instance. It decides the owner each cycle with a starvation-guarded priority policy and drives the RAM's r_en/w_en/funct/addr/wdata.
- Grants feed the stages' ready_go terms, so a losing stage simply stalls through the existing valid/allow_in handshake.

---
 rtl/mem_port_arbiter_pkg.sv | 61 ++++++
 rtl/mem_port_arbiter_if.sv | 66 ++++++
 rtl/mem_port_arbiter_starve_ctr.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 79 +++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data/fetch RAM port arbiter.
// Port ids, fetch funct and the RAM command bundle.
package mem_port_arbiter_pkg;

  localparam int XLEN    = 32;
  localparam int FUNCT_W = 10;
  localparam int SCNT_W  = 4;

  localparam int unsigned STARVE_MAX_DEF = 3;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  // Existing LW encoding: funct7 = 0, funct3 = 3'b010.
  localparam logic [FUNCT_W-1:0] FUNCT_LW =
    10'b0000000_010;

  typedef logic [XLEN-1:0]    word_t;
  typedef logic [FUNCT_W-1:0] funct_t;

  typedef struct packed {
    logic   r_en;
    logic   w_en;
    funct_t funct;
    word_t  addr;
    word_t  wdata;
  } mem_cmd_t;

  function automatic mem_cmd_t cmd_idle();
    mem_cmd_t c;
    c = '0;
    return c;
  endfunction

  function automatic mem_cmd_t cmd_fetch(
    input word_t addr
  );
    mem_cmd_t c;
    c       = '0;
    c.r_en  = 1'b1;
    c.funct = FUNCT_LW;
    c.addr  = addr;
    return c;
  endfunction

  function automatic mem_cmd_t cmd_data(
    input logic   we,
    input funct_t funct,
    input word_t  addr,
    input word_t  wdata
  );
    mem_cmd_t c;
    c.r_en  = ~we;
    c.w_en  = we;
    c.funct = funct;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two requesting stages, the RAM and the arbiter.
// slave = arbiter side, master = stages/RAM side.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic   d_req;
  logic   d_we;
  funct_t d_funct;
  word_t  d_addr;
  word_t  d_wdata;
  logic   d_gnt;
  word_t  d_rdata;

  logic   i_req;
  word_t  i_addr;
  logic   i_gnt;
  word_t  i_rdata;

  logic   mem_r_en;
  logic   mem_w_en;
  funct_t mem_funct;
  word_t  mem_addr;
  word_t  mem_wdata;
  word_t  mem_rdata;

  modport slave (
    input  d_req,
    input  d_we,
    input  d_funct,
    input  d_addr,
    input  d_wdata,
    output d_gnt,
    output d_rdata,
    input  i_req,
    input  i_addr,
    output i_gnt,
    output i_rdata,
    output mem_r_en,
    output mem_w_en,
    output mem_funct,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport master (
    output d_req,
    output d_we,
    output d_funct,
    output d_addr,
    output d_wdata,
    input  d_gnt,
    input  d_rdata,
    output i_req,
    output i_addr,
    input  i_gnt,
    input  i_rdata,
    input  mem_r_en,
    input  mem_w_en,
    input  mem_funct,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts consecutive fetch losses; raises force_fetch once the
// count reaches STARVE_MAX so fetch wins the next conflict.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic force_fetch
);

  localparam logic [SCNT_W-1:0] MAX =
    SCNT_W'(STARVE_MAX);

  logic [SCNT_W-1:0] cnt;
  logic [SCNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (!i_req || i_gnt) begin
      cnt_nxt = '0;
    end else if (cnt != MAX) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign force_fetch = (cnt == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported data RAM between the memory-access
// stage (D) and instruction fetch (I); one grant per cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit          RR_MODE    = 1'b0,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic     conflict;
  logic     force_fetch;
  logic     fetch_wins;
  logic     last_win;
  logic     go_d;
  logic     go_i;
  mem_cmd_t cmd;

  assign conflict = bus.d_req & bus.i_req;

  // Mode 1 hands the conflict to whoever did not win the last one.
  assign fetch_wins = RR_MODE ? (last_win == PORT_D)
                              : force_fetch;

  always_comb begin
    go_d = 1'b0;
    go_i = 1'b0;
    if (!rst) begin
      go_d = bus.d_req & ~(bus.i_req & fetch_wins);
      go_i = bus.i_req & ~(bus.d_req & ~fetch_wins);
    end
  end

  always_comb begin
    cmd = cmd_idle();
    unique case (1'b1)
      go_i:    cmd = cmd_fetch(bus.i_addr);
      go_d:    cmd = cmd_data(bus.d_we, bus.d_funct,
                              bus.d_addr, bus.d_wdata);
      default: ;
    endcase
  end

  assign bus.d_gnt     = go_d;
  assign bus.i_gnt     = go_i;
  assign bus.mem_r_en  = cmd.r_en;
  assign bus.mem_w_en  = cmd.w_en;
  assign bus.mem_funct = cmd.funct;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.d_rdata   = go_d ? bus.mem_rdata : '0;
  assign bus.i_rdata   = go_i ? bus.mem_rdata : '0;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .i_req       (bus.i_req),
    .i_gnt       (go_i),
    .force_fetch (force_fetch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_win     <= PORT_D;
      conflict_cnt <= '0;
    end else if (conflict) begin
      last_win     <= go_i ? PORT_I : PORT_D;
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: priority (4-bit counter) and round-robin arbiters
// share one stimulus and are checked against a reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int SMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst;
  logic   d_req;
  logic   d_we;
  funct_t d_funct;
  word_t  d_addr;
  word_t  d_wdata;
  logic   i_req;
  word_t  i_addr;

  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  logic [31:0] ram_a [256] = '{default: '0};
  logic [31:0] ram_b [256] = '{default: '0};

  assign bus_a.d_req     = d_req;
  assign bus_a.d_we      = d_we;
  assign bus_a.d_funct   = d_funct;
  assign bus_a.d_addr    = d_addr;
  assign bus_a.d_wdata   = d_wdata;
  assign bus_a.i_req     = i_req;
  assign bus_a.i_addr    = i_addr;
  assign bus_a.mem_rdata = ram_a[bus_a.mem_addr[9:2]];

  assign bus_b.d_req     = d_req;
  assign bus_b.d_we      = d_we;
  assign bus_b.d_funct   = d_funct;
  assign bus_b.d_addr    = d_addr;
  assign bus_b.d_wdata   = d_wdata;
  assign bus_b.i_req     = i_req;
  assign bus_b.i_addr    = i_addr;
  assign bus_b.mem_rdata = ram_b[bus_b.mem_addr[9:2]];

  always @(posedge clk) begin
    if (bus_a.mem_w_en)
      ram_a[bus_a.mem_addr[9:2]] <= bus_a.mem_wdata;
    if (bus_b.mem_w_en)
      ram_b[bus_b.mem_addr[9:2]] <= bus_b.mem_wdata;
  end

  mem_port_arbiter #(
    .RR_MODE    (1'b0),
    .STARVE_MAX (SMAX),
    .CNT_W      (4)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_a),
    .conflict_cnt (cnt_a)
  );

  mem_port_arbiter #(
    .RR_MODE    (1'b1),
    .STARVE_MAX (SMAX),
    .CNT_W      (32)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_b),
    .conflict_cnt (cnt_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: k=0 priority + starvation, k=1 round-robin.
  int          m_loss [2] = '{0, 0};
  bit          m_last [2] = '{0, 0};
  logic [31:0] m_cnt  [2] = '{0, 0};
  logic [31:0] m_mem  [2][256] = '{default: '0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic        dg, ig, re, we_o, edg, eig, fw;
      logic [9:0]  fn;
      logic [31:0] ad, wd, dr, ir, cc, ecc;
      string       p;
      p = (k == 0) ? "a" : "b";
      if (k == 0) begin
        dg = bus_a.d_gnt; ig = bus_a.i_gnt;
        re = bus_a.mem_r_en; we_o = bus_a.mem_w_en;
        fn = bus_a.mem_funct; ad = bus_a.mem_addr;
        wd = bus_a.mem_wdata; dr = bus_a.d_rdata;
        ir = bus_a.i_rdata; cc = {28'b0, cnt_a};
      end else begin
        dg = bus_b.d_gnt; ig = bus_b.i_gnt;
        re = bus_b.mem_r_en; we_o = bus_b.mem_w_en;
        fn = bus_b.mem_funct; ad = bus_b.mem_addr;
        wd = bus_b.mem_wdata; dr = bus_b.d_rdata;
        ir = bus_b.i_rdata; cc = cnt_b;
      end
      edg = 1'b0;
      eig = 1'b0;
      if (!rst) begin
        if (d_req && i_req) begin
          fw  = (k == 1) ? (m_last[k] == 1'b0)
                         : (m_loss[k] == SMAX);
          eig = fw;
          edg = !fw;
        end else begin
          edg = d_req;
          eig = i_req;
        end
      end
      ecc = (k == 0) ? (m_cnt[k] & 32'hF) : m_cnt[k];
      chk({p, " d_gnt"}, 32'(dg), 32'(edg));
      chk({p, " i_gnt"}, 32'(ig), 32'(eig));
      chk({p, " conflict_cnt"}, cc, ecc);
      chk({p, " mem_r_en"}, 32'(re),
          32'(eig || (edg && !d_we)));
      chk({p, " mem_w_en"}, 32'(we_o), 32'(edg && d_we));
      if (eig) begin
        chk({p, " f funct"}, 32'(fn), 32'(FUNCT_LW));
        chk({p, " f addr"}, ad, i_addr);
        chk({p, " i_rdata"}, ir, m_mem[k][i_addr[9:2]]);
      end else begin
        chk({p, " i_rdata idle"}, ir, 32'h0);
      end
      if (edg) begin
        chk({p, " d funct"}, 32'(fn), 32'(d_funct));
        chk({p, " d addr"}, ad, d_addr);
        chk({p, " d wdata"}, wd, d_wdata);
        if (!d_we)
          chk({p, " d_rdata"}, dr, m_mem[k][d_addr[9:2]]);
      end else begin
        chk({p, " d_rdata idle"}, dr, 32'h0);
      end
      if (!rst && !d_req && !i_req) begin
        chk({p, " idle funct"}, 32'(fn), 32'h0);
        chk({p, " idle addr"}, ad, 32'h0);
        chk({p, " idle wdata"}, wd, 32'h0);
      end
      if (rst) begin
        m_loss[k] = 0;
        m_last[k] = 1'b0;
        m_cnt[k]  = '0;
      end else begin
        if (d_req && i_req) begin
          m_cnt[k]  = m_cnt[k] + 1;
          m_last[k] = eig;
        end
        if (i_req && !eig)
          m_loss[k] = (m_loss[k] < SMAX) ? m_loss[k] + 1 : SMAX;
        else
          m_loss[k] = 0;
        if (edg && d_we)
          m_mem[k][d_addr[9:2]] = d_wdata;
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r,
                       input logic dq, input logic we,
                       input logic [9:0] fn,
                       input logic [31:0] da,
                       input logic [31:0] wdat,
                       input logic iq,
                       input logic [31:0] ia);
    rst = r; d_req = dq; d_we = we; d_funct = fn;
    d_addr = da; d_wdata = wdat; i_req = iq; i_addr = ia;
  endtask

  logic [7:0] seq_a;
  logic [7:0] seq_b;

  initial begin
    drive(1, 1, 1, 10'h2, 32'h100, 32'h1111, 1, 32'h100);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst d_gnt", 32'(bus_a.d_gnt), 32'h0);
      chk("rst i_gnt", 32'(bus_b.i_gnt), 32'h0);
      chk("rst r_en", 32'(bus_a.mem_r_en), 32'h0);
      chk("rst w_en", 32'(bus_a.mem_w_en), 32'h0);
      next();
    end

    drive(0, 0, 0, 10'h0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("post-rst cnt a", 32'(cnt_a), 32'h0);
    chk("post-rst cnt b", cnt_b, 32'h0);
    next();

    drive(0, 1, 1, 10'h2, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    @(negedge clk);
    chk("store d_gnt", 32'(bus_a.d_gnt), 32'h1);
    chk("store w_en", 32'(bus_a.mem_w_en), 32'h1);
    next();

    drive(0, 0, 0, 10'h0, 32'h0, 32'h0, 1, 32'h100);
    @(negedge clk);
    chk("fetch i_gnt", 32'(bus_a.i_gnt), 32'h1);
    chk("fetch i_rdata", bus_a.i_rdata, 32'hDEADBEEF);
    chk("fetch cnt", 32'(cnt_a), 32'h0);
    next();

    drive(0, 1, 1, 10'h2, 32'h40, 32'h12345678, 0, 32'h0);
    next();
    drive(0, 1, 0, 10'h2, 32'h40, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("load d_gnt", 32'(bus_a.d_gnt), 32'h1);
    chk("load d_rdata", bus_a.d_rdata, 32'h12345678);
    chk("load i_rdata", bus_a.i_rdata, 32'h0);
    next();

    drive(0, 1, 0, 10'h1, 32'h40, 32'h0, 1, 32'h100);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seq_a[c] = bus_a.i_gnt;
      seq_b[c] = bus_b.i_gnt;
      next();
    end
    drive(0, 0, 0, 10'h0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("starve seq a", 32'(seq_a), 32'h88);
    chk("rr seq b", 32'(seq_b[3:0]), 32'h5);
    chk("starve cnt a", 32'(cnt_a), 32'h8);
    chk("starve cnt b", cnt_b, 32'h8);
    next();

    drive(0, 1, 1, 10'h0, 32'h20, 32'hA5A5_0000, 1, 32'h40);
    for (int c = 0; c < 9; c++) begin
      d_wdata = 32'hA5A5_0000 + 32'(c);
      next();
    end
    drive(0, 0, 0, 10'h0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("wrap cnt a", 32'(cnt_a), 32'h1);
    chk("wrap cnt b", cnt_b, 32'd17);
    next();

    drive(1, 1, 1, 10'h2, 32'h80, 32'hCAFEF00D, 1, 32'h100);
    @(negedge clk);
    chk("midrst d_gnt", 32'(bus_a.d_gnt), 32'h0);
    chk("midrst w_en", 32'(bus_a.mem_w_en), 32'h0);
    next();
    drive(0, 0, 0, 10'h0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("midrst cnt a", 32'(cnt_a), 32'h0);
    next();
    drive(0, 1, 0, 10'h2, 32'h80, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("dropped store", bus_a.d_rdata, 32'h0);
    next();
    drive(0, 1, 0, 10'h2, 32'h20, 32'h0, 1, 32'h40);
    @(negedge clk);
    chk("1st conflict a", 32'(bus_a.d_gnt), 32'h1);
    chk("1st conflict b", 32'(bus_b.i_gnt), 32'h1);
    next();
    drive(0, 0, 0, 10'h0, 32'h0, 32'h0, 0, 32'h0);
    next();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
